// File: rtl/riscv_pkg.sv
// Shared load/store encodings and MMIO register offsets.
// Used by data_memory and mmio_responder.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [7:0] OFF_TOHOST      = 8'h00;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h08;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h0C;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h10;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h14;
    localparam logic [7:0] OFF_TX_DATA     = 8'h18;
    localparam logic [7:0] OFF_STATUS      = 8'h1C;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console byte FIFO with wrap-bit pointers.
// Caller guarantees push is only raised when there is room.
module mmio_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [4:0] count,
    output logic [7:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = 5'(wptr - rptr);
    assign rdata = empty ? 8'h00 : mem[rptr[AW-1:0]];

    // Pointer advance and storage write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MEM-stage MMIO target: tohost halt, machine timer, byte console.
// Claims a 256-byte window at BASE_ADDR; read_data is zero off-window.
module mmio_responder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        halt,
    output logic [30:0] halt_code,
    output logic        timer_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    function automatic logic [3:0] size_mask(input logic [1:0] sz,
                                             input logic [1:0] ln);
        logic [3:0] m;
        m = 4'b0000;
        unique case (sz)
            SZ_BYTE: m = 4'b0001 << ln;
            SZ_HALF: m = (ln == 2'd3) ? 4'b0000 : (4'b0011 << ln);
            SZ_WORD: m = (ln == 2'd0) ? 4'b1111 : 4'b0000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_insert(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  m,
                                                input logic [1:0]  ln);
        logic [31:0] sh;
        logic [31:0] bm;
        sh = data << {ln, 3'b000};
        bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        return (old & ~bm) | (sh & bm);
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  ln);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {ln, 3'b000};
        r  = 32'h0;
        unique case (f3)
            F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
            F3_LW:   r = sh;
            F3_LBU:  r = {24'h0, sh[7:0]};
            F3_LHU:  r = {16'h0, sh[15:0]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    logic [1:0]  lane;
    logic [7:0]  woff;
    logic        store_ok;
    logic        load_ok;
    logic [3:0]  st_mask;
    logic [3:0]  ld_mask;
    logic        we;
    logic        wr_tohost, wr_mlo, wr_mhi, wr_clo, wr_chi, wr_tx, wr_status;
    logic [31:0] tohost;
    logic [31:0] mtime_lo, mtime_hi;
    logic [31:0] cmp_lo, cmp_hi;
    logic [63:0] mtime_nxt;
    logic        ovf;
    logic [31:0] rd_word;
    logic [31:0] st_word;
    logic        fifo_full, fifo_empty, push, pop;
    logic [4:0]  fifo_count;

    assign lane     = address[1:0];
    assign woff     = {address[7:2], 2'b00};
    assign hit      = (address[31:8] == BASE_ADDR[31:8]);
    assign store_ok = funct3 inside {F3_SB, F3_SH, F3_SW};
    assign load_ok  = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    assign st_mask  = store_ok ? size_mask(funct3[1:0], lane) : 4'b0000;
    assign ld_mask  = load_ok ? size_mask(funct3[1:0], lane) : 4'b0000;
    assign we       = hit && MemWrite && (st_mask != 4'b0000);

    assign wr_tohost = we && (woff == OFF_TOHOST);
    assign wr_mlo    = we && (woff == OFF_MTIME_LO);
    assign wr_mhi    = we && (woff == OFF_MTIME_HI);
    assign wr_clo    = we && (woff == OFF_MTIMECMP_LO);
    assign wr_chi    = we && (woff == OFF_MTIMECMP_HI);
    assign wr_tx     = we && (woff == OFF_TX_DATA);
    assign wr_status = we && (woff == OFF_STATUS);

    // Register read mux; also the old value for sub-word merges.
    always_comb begin
        rd_word = 32'h0;
        case (woff)
            OFF_TOHOST:      rd_word = tohost;
            OFF_MTIME_LO:    rd_word = mtime_lo;
            OFF_MTIME_HI:    rd_word = mtime_hi;
            OFF_MTIMECMP_LO: rd_word = cmp_lo;
            OFF_MTIMECMP_HI: rd_word = cmp_hi;
            OFF_STATUS:      rd_word = {19'h0, fifo_count, 5'h0,
                                        ovf, fifo_full, fifo_empty};
            default:         rd_word = 32'h0;
        endcase
    end

    assign st_word   = lane_insert(rd_word, write_data, st_mask, lane);
    assign read_data = (hit && MemRead && (ld_mask != 4'b0000))
                     ? lane_extract(rd_word, funct3, lane) : 32'h0;

    // Next mtime: increment unless halted, a written half overrides.
    always_comb begin
        mtime_nxt = {mtime_hi, mtime_lo} + {63'h0, ~halt};
        if (wr_mlo) mtime_nxt[31:0]  = st_word;
        if (wr_mhi) mtime_nxt[63:32] = st_word;
    end

    // Timer, compare and registered interrupt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_lo  <= 32'h0;
            mtime_hi  <= 32'h0;
            cmp_lo    <= 32'hFFFF_FFFF;
            cmp_hi    <= 32'hFFFF_FFFF;
            timer_irq <= 1'b0;
        end else begin
            {mtime_hi, mtime_lo} <= mtime_nxt;
            if (wr_clo) cmp_lo <= st_word;
            if (wr_chi) cmp_hi <= st_word;
            timer_irq <= ({mtime_hi, mtime_lo} >= {cmp_hi, cmp_lo});
        end
    end

    // tohost capture; halting write freezes further tohost updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost    <= 32'h0;
            halt      <= 1'b0;
            halt_code <= 31'h0;
        end else if (wr_tohost && !halt) begin
            tohost <= st_word;
            if (st_word[0]) begin
                halt      <= 1'b1;
                halt_code <= st_word[31:1];
            end
        end
    end

    assign pop      = tx_valid && tx_ready;
    assign push     = wr_tx && (!fifo_full || pop);
    assign tx_valid = !fifo_empty;

    // Sticky overflow: set on a dropped byte, cleared by W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wr_tx && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (wr_status && st_mask[0] && write_data[2]) begin
            ovf <= 1'b0;
        end
    end

    mmio_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata (write_data[7:0]),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .rdata (tx_data)
    );

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: behavioural model plus directed vectors.
// Every cycle the outputs are compared against the model.
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic        tx_ready = 1'b0;
    logic [31:0] read_data;
    logic        hit;
    logic        halt;
    logic [30:0] halt_code;
    logic        timer_irq;
    logic        tx_valid;
    logic [7:0]  tx_data;

    mmio_responder #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .funct3     (funct3),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit),
        .halt       (halt),
        .halt_code  (halt_code),
        .timer_irq  (timer_irq),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- model ----------------
    logic [31:0] m_tohost = 32'h0;
    logic [63:0] m_mtime = 64'h0;
    logic [63:0] m_cmp = '1;
    logic        m_halt = 1'b0;
    logic [30:0] m_code = 31'h0;
    logic        m_irq = 1'b0;
    logic        m_ovf = 1'b0;
    logic [7:0]  m_q[$];
    logic [7:0]  seen[$];

    function automatic int nbytes(input logic [2:0] f3, input bit ld);
        if (ld) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit fits(input int n, input logic [1:0] ln);
        return (n != 0) && (int'(ln) + n <= 4) && (n != 4 || ln == 0);
    endfunction

    function automatic logic [31:0] m_word(input logic [7:0] off);
        int sz;
        sz = m_q.size();
        case (off)
            8'h00:   return m_tohost;
            8'h08:   return m_mtime[31:0];
            8'h0C:   return m_mtime[63:32];
            8'h10:   return m_cmp[31:0];
            8'h14:   return m_cmp[63:32];
            8'h1C:   return (sz << 8) + (int'(m_ovf) << 2)
                          + (int'(sz == DEPTH) << 1) + int'(sz == 0);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read();
        int      n;
        longint  v;
        logic [1:0] ln;
        if (address[31:8] != BASE[31:8] || !MemRead) return 32'h0;
        n  = nbytes(funct3, 1'b1);
        ln = address[1:0];
        if (!fits(n, ln)) return 32'h0;
        v = longint'(m_word({address[7:2], 2'b00}) >> (8 * ln));
        v = v & ((64'd1 << (8 * n)) - 1);
        if (!funct3[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old,
                                            input int n,
                                            input logic [1:0] ln);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < n; b++)
            r[8 * (int'(ln) + b) +: 8] = write_data[8 * b +: 8];
        return r;
    endfunction

    task automatic model_step();
        int          n;
        logic [1:0]  ln;
        logic [7:0]  off;
        logic [63:0] old_t;
        logic [31:0] t;
        bit          wr;
        bit          pop;
        n     = nbytes(funct3, 1'b0);
        ln    = address[1:0];
        off   = {address[7:2], 2'b00};
        wr    = MemWrite && (address[31:8] == BASE[31:8]) && fits(n, ln);
        pop   = (m_q.size() != 0) && tx_ready;
        old_t = m_mtime;
        m_irq = (m_mtime >= m_cmp);
        if (!m_halt) m_mtime = m_mtime + 1;
        if (pop) void'(m_q.pop_front());
        if (wr) begin
            case (off)
                8'h00: if (!m_halt) begin
                    t = m_merge(m_tohost, n, ln);
                    m_tohost = t;
                    if (t[0]) begin
                        m_halt = 1'b1;
                        m_code = t[31:1];
                    end
                end
                8'h08: m_mtime[31:0]  = m_merge(old_t[31:0], n, ln);
                8'h0C: m_mtime[63:32] = m_merge(old_t[63:32], n, ln);
                8'h10: m_cmp[31:0]    = m_merge(m_cmp[31:0], n, ln);
                8'h14: m_cmp[63:32]   = m_merge(m_cmp[63:32], n, ln);
                8'h18: if (m_q.size() < DEPTH) m_q.push_back(write_data[7:0]);
                       else m_ovf = 1'b1;
                8'h1C: if (ln == 0 && write_data[2]) m_ovf = 1'b0;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_tohost = 32'h0;
            m_mtime  = 64'h0;
            m_cmp    = '1;
            m_halt   = 1'b0;
            m_code   = 31'h0;
            m_irq    = 1'b0;
            m_ovf    = 1'b0;
            m_q.delete();
        end else begin
            model_step();
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("hit", hit, address[31:8] == BASE[31:8]);
        chk("read_data", read_data, m_read());
        chk("halt", halt, m_halt);
        chk("halt_code", halt_code, m_code);
        chk("timer_irq", timer_irq, m_irq);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        chk("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
        if (reset && tx_valid && tx_ready) seen.push_back(tx_data);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc();
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
        cyc();
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
        funct3     = f3;
        address    = a;
        write_data = d;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                      output logic [31:0] v);
        cyc();
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        funct3   = f3;
        address  = a;
        #2;
        v = read_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] t;
        int          n;

        cyc();
        cyc();
        chk("rst_halt", halt, 0);
        chk("rst_code", halt_code, 0);
        chk("rst_irq", timer_irq, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_read", read_data, 0);
        reset = 1'b1;

        // Two console bytes, held back, then drained.
        st(3'd2, BASE + 32'h18, 32'h41);
        st(3'd2, BASE + 32'h18, 32'h42);
        ld(3'd2, BASE + 32'h1C, v);
        chk("status_cnt2", v, 32'h0000_0200);
        chk("head_valid", tx_valid, 1);
        chk("head_data", tx_data, 8'h41);
        idle();
        seen.delete();
        tx_ready = 1'b1;
        repeat (4) cyc();
        tx_ready = 1'b0;
        chk("drain_len", seen.size(), 2);
        if (seen.size() == 2) begin
            chk("drain0", seen[0], 8'h41);
            chk("drain1", seen[1], 8'h42);
        end
        chk("drain_empty", tx_valid, 0);

        // Overflow with nine pushes, then W1C.
        for (int i = 0; i < 9; i++) st(3'd0, BASE + 32'h18, 32'h10 + i);
        ld(3'd2, BASE + 32'h1C, v);
        chk("status_full_ovf", v, 32'h0000_0806);
        st(3'd2, BASE + 32'h1C, 32'h4);
        ld(3'd2, BASE + 32'h1C, v);
        chk("status_ovf_clr", v, 32'h0000_0802);
        idle();
        seen.delete();
        tx_ready = 1'b1;
        repeat (10) cyc();
        tx_ready = 1'b0;
        chk("ovf_drain_len", seen.size(), 8);
        for (int i = 0; i < seen.size(); i++)
            chk("ovf_drain_byte", seen[i], 8'h10 + i);
        ld(3'd2, BASE + 32'h1C, v);
        chk("status_empty", v, 32'h0000_0001);

        // Timer compare latency.
        st(3'd2, BASE + 32'h14, 32'h0);
        ld(3'd2, BASE + 32'h08, t);
        st(3'd2, BASE + 32'h10, t + 32'd21);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            idle();
            if (timer_irq) begin
                n = i;
                break;
            end
        end
        chk("irq_latency", n, 21);

        // Sub-word store/load on tohost, no halt.
        st(3'd0, BASE + 32'h01, 32'h80);
        ld(3'd0, BASE + 32'h01, v);
        chk("lb_sign", v, 32'hFFFF_FF80);
        ld(3'd4, BASE + 32'h01, v);
        chk("lbu_zero", v, 32'h0000_0080);
        ld(3'd1, BASE + 32'h01, v);
        chk("lh_off1", v, 32'h0000_0080);
        ld(3'd2, BASE + 32'h02, v);
        chk("lw_misaligned", v, 32'h0);
        st(3'd1, BASE + 32'h03, 32'hFFFF);
        ld(3'd2, BASE, v);
        chk("sh_misaligned_nop", v, 32'h0000_8000);
        chk("no_halt", halt, 0);
        ld(3'd2, 32'h5000_0000, v);
        chk("miss_read", v, 32'h0);
        chk("miss_hit", hit, 0);

        // Halting write; later writes ignored.
        st(3'd2, BASE, 32'h3);
        idle();
        chk("halt_set", halt, 1);
        chk("halt_code", halt_code, 31'h1);
        st(3'd2, BASE, 32'h5);
        idle();
        chk("halt_code_keep", halt_code, 31'h1);
        ld(3'd2, BASE, v);
        chk("tohost_keep", v, 32'h3);

        // Console still works while halted; reset mid-drain.
        st(3'd0, BASE + 32'h18, 32'h61);
        st(3'd0, BASE + 32'h18, 32'h62);
        st(3'd0, BASE + 32'h18, 32'h63);
        idle();
        tx_ready = 1'b1;
        cyc();
        chk("mid_drain_valid", tx_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_halt", halt, 0);
        chk("async_code", halt_code, 0);
        chk("async_irq", timer_irq, 0);
        chk("async_read", read_data, 0);
        cyc();
        reset = 1'b1;
        tx_ready = 1'b0;
        ld(3'd2, BASE + 32'h10, v);
        chk("cmp_lo_reset", v, 32'hFFFF_FFFF);
        ld(3'd2, BASE + 32'h1C, v);
        chk("status_reset", v, 32'h0000_0001);
        idle();
        cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
